// File: rtl/ctrl_dma_burst_trigger_if.sv
// Purpose : groups the command/DMA handshake nets of ctrl_dma_burst_trigger.
// Latency : none (wires only).
// Backpressure: drq is held until ack or abort/timeout; ack is ignored while drq is low.
// Ports   : control_bus (command word), ack (DMA acknowledge), drq (DMA request),
//           busy/done/aborted/timeout/overrun status nets, remaining (requests left).
//           master = the burst trigger, slave = the command/DMA side.
interface ctrl_dma_burst_trigger_if;
  logic [7:0] control_bus;
  logic       ack;
  logic       drq;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       timeout;
  logic       overrun;
  logic [6:0] remaining;

  modport master (
    input  control_bus, ack,
    output drq, busy, done, aborted, timeout, overrun, remaining
  );

  modport slave (
    output control_bus, ack,
    input  drq, busy, done, aborted, timeout, overrun, remaining
  );
endinterface

// File: rtl/ctrl_dma_burst_trigger.sv
// Purpose : turns a start/abort/count command word into a paced burst of drq/ack handshakes.
// Latency : start seen on control_bus[0] at edge k -> drq high after edge k+2 (synchronized) or k.
// Backpressure: drq stays high until ack, abort or ack timeout; gap of GapCycles between requests.
// Ports   : clock, reset (async, active high); bus.control_bus [0]=start [1]=abort [7:2]=len-1;
//           bus.ack in; bus.drq, busy, done, aborted, timeout, overrun, remaining out.
module ctrl_dma_burst_trigger #(
  parameter int SyncInputs = 1,
  parameter int GapCycles  = 2,
  parameter int AckTimeout = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  ctrl_dma_burst_trigger_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0]  GAP_LOAD = 8'(GapCycles);
  localparam bit          TO_EN    = (AckTimeout != 0);
  // Counter value on the last cycle drq is allowed to wait for ack.
  localparam logic [15:0] TO_LAST  = TO_EN ? 16'(AckTimeout - 1) : 16'd0;

  // ---------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------
  logic [7:0] cs;

  generate
    if (SyncInputs != 0) begin : g_sync
      logic [7:0] sync1;
      logic [7:0] sync2;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync1 <= '0;
          sync2 <= '0;
        end else begin
          sync1 <= bus.control_bus;
          sync2 <= sync1;
        end
      end

      assign cs = sync2;
    end else begin : g_nosync
      assign cs = bus.control_bus;
    end
  endgenerate

  logic cs0_q;
  logic start_edge;
  logic abort_lvl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs0_q <= 1'b0;
    end else begin
      cs0_q <= cs[0];
    end
  end

  // Holding start high yields a single edge; re-arming needs start low first.
  assign start_edge = cs[0] & ~cs0_q;
  assign abort_lvl  = cs[1];

  // ---------------------------------------------------------------
  // FSM and datapath state
  // ---------------------------------------------------------------
  state_t      state,      state_nx;
  logic [6:0]  rem,        rem_nx;
  logic [7:0]  gap_cnt,    gap_nx;
  logic [15:0] to_cnt,     to_nx;
  logic        overrun_q,  overrun_nx;
  logic        done_q,     done_nx;
  logic        aborted_q,  aborted_nx;
  logic        timeout_q,  timeout_nx;
  logic        drq_q;
  logic        busy_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= '0;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      timeout_q <= 1'b0;
      drq_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      rem       <= rem_nx;
      gap_cnt   <= gap_nx;
      to_cnt    <= to_nx;
      overrun_q <= overrun_nx;
      done_q    <= done_nx;
      aborted_q <= aborted_nx;
      timeout_q <= timeout_nx;
      // drq and busy are flopped copies of the next-state decode so they
      // change glitch-free, in the same cycle as the state register.
      drq_q     <= (state_nx == REQ);
      busy_q    <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx   = state;
    rem_nx     = rem;
    gap_nx     = gap_cnt;
    to_nx      = to_cnt;
    overrun_nx = overrun_q;
    done_nx    = 1'b0;
    aborted_nx = 1'b0;
    timeout_nx = 1'b0;

    // A start edge during a burst is flagged but otherwise ignored.
    if ((state != IDLE) && start_edge) begin
      overrun_nx = 1'b1;
    end

    case (state)
      IDLE: begin
        // An abort level held in IDLE blocks the start without a pulse.
        if (start_edge && !abort_lvl) begin
          rem_nx     = {1'b0, cs[7:2]} + 7'd1;
          overrun_nx = 1'b0;
          to_nx      = '0;
          state_nx   = REQ;
        end
      end

      REQ: begin
        // Abort beats a same-cycle ack, and ack beats a same-cycle timeout.
        if (abort_lvl) begin
          aborted_nx = 1'b1;
          rem_nx     = '0;
          state_nx   = IDLE;
        end else if (bus.ack) begin
          rem_nx = rem - 7'd1;
          if (rem == 7'd1) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            gap_nx   = GAP_LOAD;
            state_nx = GAP;
          end
        end else if (TO_EN && (to_cnt == TO_LAST)) begin
          // remaining is left untouched so software can see where it stalled.
          timeout_nx = 1'b1;
          state_nx   = IDLE;
        end else if (TO_EN) begin
          to_nx = to_cnt + 16'd1;
        end
      end

      GAP: begin
        // ack is not looked at here: it is only meaningful while drq is high.
        if (abort_lvl) begin
          aborted_nx = 1'b1;
          rem_nx     = '0;
          state_nx   = IDLE;
        end else if (gap_cnt <= 8'd1) begin
          to_nx    = '0;
          state_nx = REQ;
        end else begin
          gap_nx = gap_cnt - 8'd1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.drq       = drq_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.timeout   = timeout_q;
  assign bus.overrun   = overrun_q;
  assign bus.remaining = rem;

  // ---------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------
  a_pulses_exclusive: assert property (@(posedge clock) disable iff (reset)
    $onehot0({done_q, aborted_q, timeout_q}));

  a_remaining_range: assert property (@(posedge clock) disable iff (reset)
    rem <= 7'd64);

  a_drq_matches_state: assert property (@(posedge clock) disable iff (reset)
    drq_q == (state == REQ));

endmodule

// File: tb/tb_ctrl_dma_burst_trigger.sv
// Purpose : directed self-checking bench for ctrl_dma_burst_trigger.
// Latency : n/a.
// Backpressure: bench plays the DMA side, acking on its own schedule.
module tb_ctrl_dma_burst_trigger;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  ctrl_dma_burst_trigger_if bus_if();

  ctrl_dma_burst_trigger #(
    .SyncInputs (1),
    .GapCycles  (2),
    .AckTimeout (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_drq(input string tag);
    int w;
    w = 0;
    while (bus_if.drq !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk(tag, 32'(bus_if.drq), 32'd1);
  endtask

  task automatic ack_one();
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int reqs;
    int dones;
    int maxrem;
    int hcnt;

    bus_if.control_bus = 8'h00;
    bus_if.ack         = 1'b0;
    ticks(2);
    #2;
    chk("rst_drq",  32'(bus_if.drq),       32'd0);
    chk("rst_busy", 32'(bus_if.busy),      32'd0);
    chk("rst_rem",  32'(bus_if.remaining), 32'd0);
    chk("rst_pulses", 32'({bus_if.done, bus_if.aborted, bus_if.timeout, bus_if.overrun}), 32'd0);
    reset = 1'b0;
    ticks(2);

    // ---- T1: count 4, ack one cycle after each drq, gap of 2 ----
    bus_if.control_bus = 8'h0D;
    tick();
    chk("t1_lat1", 32'(bus_if.drq), 32'd0);
    tick();
    chk("t1_lat2", 32'(bus_if.drq), 32'd0);
    tick();
    chk("t1_lat3_drq",  32'(bus_if.drq),  32'd1);
    chk("t1_lat3_busy", 32'(bus_if.busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_req_drq", 32'(bus_if.drq),       32'd1);
      chk("t1_req_rem", 32'(bus_if.remaining), 32'(4 - i));
      tick();
      chk("t1_hold_drq", 32'(bus_if.drq), 32'd1);
      ack_one();
      if (i < 3) begin
        chk("t1_gap0_drq", 32'(bus_if.drq),       32'd0);
        chk("t1_gap0_rem", 32'(bus_if.remaining), 32'(3 - i));
        chk("t1_gap0_done", 32'(bus_if.done),     32'd0);
        tick();
        chk("t1_gap1_drq", 32'(bus_if.drq), 32'd0);
        tick();
      end else begin
        chk("t1_done",     32'(bus_if.done),      32'd1);
        chk("t1_end_busy", 32'(bus_if.busy),      32'd0);
        chk("t1_end_drq",  32'(bus_if.drq),       32'd0);
        chk("t1_end_rem",  32'(bus_if.remaining), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(bus_if.done), 32'd0);
      end
    end
    ticks(3);
    chk("t1_held_start_no_rearm", 32'(bus_if.busy), 32'd0);
    bus_if.control_bus = 8'h00;
    ticks(4);

    // ---- T2: count 64, ack held high ----
    bus_if.control_bus = 8'hFD;
    bus_if.ack         = 1'b1;
    wait_drq("t2_start");
    chk("t2_first_rem", 32'(bus_if.remaining), 32'd64);
    reqs   = 1;
    dones  = 0;
    maxrem = 64;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (bus_if.drq === 1'b1) reqs++;
      if (bus_if.done === 1'b1) dones++;
      if (int'(bus_if.remaining) > maxrem) maxrem = int'(bus_if.remaining);
      if (bus_if.done === 1'b1) break;
    end
    chk("t2_reqs",   32'(reqs),   32'd64);
    chk("t2_dones",  32'(dones),  32'd1);
    chk("t2_maxrem", 32'(maxrem), 32'd64);
    chk("t2_busy",   32'(bus_if.busy), 32'd0);
    bus_if.ack         = 1'b0;
    bus_if.control_bus = 8'h00;
    ticks(4);

    // ---- T3: count 8, abort during request 3 ----
    bus_if.control_bus = 8'h1D;
    wait_drq("t3_req1");
    chk("t3_first_rem", 32'(bus_if.remaining), 32'd8);
    ack_one();
    wait_drq("t3_req2");
    ack_one();
    wait_drq("t3_req3");
    chk("t3_req3_rem", 32'(bus_if.remaining), 32'd6);
    bus_if.control_bus = 8'h02;
    ticks(2);
    chk("t3_still_drq", 32'(bus_if.drq), 32'd1);
    tick();
    chk("t3_drq",     32'(bus_if.drq),       32'd0);
    chk("t3_aborted", 32'(bus_if.aborted),   32'd1);
    chk("t3_rem",     32'(bus_if.remaining), 32'd0);
    chk("t3_done",    32'(bus_if.done),      32'd0);
    chk("t3_busy",    32'(bus_if.busy),      32'd0);
    tick();
    chk("t3_aborted_pulse", 32'(bus_if.aborted), 32'd0);
    bus_if.control_bus = 8'h00;
    ticks(4);

    // ---- T4: count 3, never ack, timeout after 10 cycles ----
    bus_if.control_bus = 8'h09;
    wait_drq("t4_start");
    chk("t4_load_rem", 32'(bus_if.remaining), 32'd3);
    hcnt = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus_if.drq === 1'b1) hcnt++;
      else break;
    end
    chk("t4_drq_high_cycles", 32'(hcnt), 32'd10);
    chk("t4_timeout", 32'(bus_if.timeout),   32'd1);
    chk("t4_busy",    32'(bus_if.busy),      32'd0);
    chk("t4_rem",     32'(bus_if.remaining), 32'd3);
    chk("t4_done",    32'(bus_if.done),      32'd0);
    tick();
    chk("t4_timeout_pulse", 32'(bus_if.timeout),   32'd0);
    chk("t4_rem_held",      32'(bus_if.remaining), 32'd3);
    bus_if.control_bus = 8'h00;
    ticks(4);

    // ---- T5: second start edge mid-burst ----
    bus_if.control_bus = 8'h0D;
    wait_drq("t5_start");
    chk("t5_rem", 32'(bus_if.remaining), 32'd4);
    ack_one();
    bus_if.control_bus = 8'h00;
    ticks(3);
    bus_if.control_bus = 8'h05;
    ticks(2);
    chk("t5_ovr_before", 32'(bus_if.overrun), 32'd0);
    tick();
    chk("t5_ovr",      32'(bus_if.overrun),   32'd1);
    chk("t5_busy",     32'(bus_if.busy),      32'd1);
    chk("t5_rem_kept", 32'(bus_if.remaining), 32'd3);
    for (int i = 0; i < 3; i++) begin
      wait_drq("t5_req");
      ack_one();
    end
    chk("t5_done",        32'(bus_if.done),    32'd1);
    chk("t5_ovr_sticky",  32'(bus_if.overrun), 32'd1);
    bus_if.control_bus = 8'h00;
    ticks(3);
    bus_if.control_bus = 8'h05;
    wait_drq("t5_restart");
    chk("t5_ovr_cleared", 32'(bus_if.overrun),   32'd0);
    chk("t5_new_rem",     32'(bus_if.remaining), 32'd2);

    // ---- T6b: abort and ack in the same cycle ----
    bus_if.control_bus = 8'h02;
    ticks(2);
    chk("t6_pre_drq", 32'(bus_if.drq), 32'd1);
    ack_one();
    chk("t6_ab_aborted", 32'(bus_if.aborted),   32'd1);
    chk("t6_ab_done",    32'(bus_if.done),      32'd0);
    chk("t6_ab_rem",     32'(bus_if.remaining), 32'd0);
    chk("t6_ab_drq",     32'(bus_if.drq),       32'd0);
    bus_if.control_bus = 8'h00;
    ticks(4);

    // ---- T6a: asynchronous reset mid-REQ ----
    bus_if.control_bus = 8'h0D;
    wait_drq("t6_start");
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_drq",  32'(bus_if.drq),       32'd0);
    chk("t6_rst_busy", 32'(bus_if.busy),      32'd0);
    chk("t6_rst_rem",  32'(bus_if.remaining), 32'd0);
    chk("t6_rst_pulses", 32'({bus_if.done, bus_if.aborted, bus_if.timeout, bus_if.overrun}), 32'd0);
    bus_if.control_bus = 8'h00;
    #3;
    reset = 1'b0;
    ticks(4);
    chk("t6_post_busy",   32'(bus_if.busy), 32'd0);
    chk("t6_post_pulses", 32'({bus_if.done, bus_if.aborted, bus_if.timeout}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
